// File: rtl/fpu_bus_interface.sv
// rtl/fpu_bus_interface.sv - byte-wide CPU bus front end driving the fpu start/operand handshake (optional watchdog: FPU_IF_WDOG_EN)
`timescale 1ns/1ps
module fpu_bus_interface #(
  parameter int OP_W        = 4,
  parameter int WDOG_CYCLES = 255
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            cs,
  input  logic            wr,
  input  logic            rd,
  input  logic [3:0]      addr,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  output logic            irq,
  output logic [31:0]     fpu_a_operand,
  output logic [31:0]     fpu_b_operand,
  output logic [OP_W-1:0] fpu_operation,
  output logic            fpu_start,
  input  logic [31:0]     fpu_result,
  input  logic            fpu_cmd_end,
  input  logic            fpu_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [3:0] ADDR_OP   = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'h9;

  logic [1:0]      state;
  logic [31:0]     a_reg;
  logic [31:0]     b_reg;
  logic [31:0]     result_reg;
  logic [OP_W-1:0] op_reg;
  logic            done;
  logic            err;
  logic            irq_en;
  logic            start_q;
  logic            cmd_end_q;

  logic            wr_en;
  logic            rd_en;
  logic            idle;
  logic            is_operand_addr;
  logic            is_ctrl_addr;
  logic            go_req;
  logic            ack_req;
  logic            busy_write;
  logic            cmd_end_rise;
  logic            wdog_expire;
  logic            busy_i;
  logic [7:0]      status_byte;
  logic [7:0]      op_byte;
  logic [7:0]      rd_mux;

  assign wr_en           = cs & wr;
  assign rd_en           = cs & rd;
  assign idle            = (state == ST_IDLE);
  assign is_operand_addr = (addr <= ADDR_OP);
  assign is_ctrl_addr    = (addr == ADDR_CTRL);
  assign go_req          = wr_en & is_ctrl_addr & data_in[0];
  assign ack_req         = wr_en & is_ctrl_addr & data_in[1];
  // An operand/opcode write or a GO arriving while an operation is in flight is refused.
  assign busy_write      = wr_en & ~idle & (is_operand_addr | (is_ctrl_addr & data_in[0]));
  // Only a fresh rising edge completes; a cmd_end still high from the previous op is ignored.
  assign cmd_end_rise    = fpu_cmd_end & ~cmd_end_q;
  assign busy_i          = ~idle | fpu_busy;
  assign status_byte     = {4'b0000, err, irq_en, done, busy_i};

  assign fpu_a_operand   = a_reg;
  assign fpu_b_operand   = b_reg;
  assign fpu_operation   = op_reg;
  assign fpu_start       = start_q;
  assign irq             = done & irq_en;

`ifdef FPU_IF_WDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
  logic [WDOG_W-1:0] wdog_cnt;

  // Count cycles spent in RUN; outside RUN the counter sits at zero so each op starts fresh.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wdog_cnt <= '0;
    end else if (state != ST_RUN) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // Expire on the WDOG_CYCLES-th cycle of RUN.
  assign wdog_expire = (state == ST_RUN) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  // Operand and opcode byte registers, writable only while the FSM is idle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
    end else if (wr_en && idle && is_operand_addr) begin
      case (addr)
        4'h0:    a_reg[7:0]   <= data_in;
        4'h1:    a_reg[15:8]  <= data_in;
        4'h2:    a_reg[23:16] <= data_in;
        4'h3:    a_reg[31:24] <= data_in;
        4'h4:    b_reg[7:0]   <= data_in;
        4'h5:    b_reg[15:8]  <= data_in;
        4'h6:    b_reg[23:16] <= data_in;
        4'h7:    b_reg[31:24] <= data_in;
        4'h8:    op_reg       <= data_in[OP_W-1:0];
        default: op_reg       <= op_reg;
      endcase
    end
  end

  // Control FSM plus done/err/irq_en status; later assignments give set-priority over ACK.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      cmd_end_q  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      irq_en     <= 1'b0;
      result_reg <= '0;
    end else begin
      cmd_end_q <= fpu_cmd_end;

      if (wr_en && is_ctrl_addr) begin
        irq_en <= data_in[2];
      end
      if (ack_req) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (busy_write) begin
        err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (go_req) begin
            state   <= ST_RUN;
            start_q <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cmd_end_rise) begin
            state   <= ST_CAPT;
            start_q <= 1'b0;
          end else if (wdog_expire) begin
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            err        <= 1'b1;
            done       <= 1'b1;
            result_reg <= QNAN;
          end
        end
        ST_CAPT: begin
          result_reg <= fpu_result;
          done       <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  // Read-data selection; unmapped addresses return zero.
  always_comb begin
    op_byte             = '0;
    op_byte[OP_W-1:0]   = op_reg;
    rd_mux              = 8'h00;
    case (addr)
      4'h0:    rd_mux = a_reg[7:0];
      4'h1:    rd_mux = a_reg[15:8];
      4'h2:    rd_mux = a_reg[23:16];
      4'h3:    rd_mux = a_reg[31:24];
      4'h4:    rd_mux = b_reg[7:0];
      4'h5:    rd_mux = b_reg[15:8];
      4'h6:    rd_mux = b_reg[23:16];
      4'h7:    rd_mux = b_reg[31:24];
      4'h8:    rd_mux = op_byte;
      4'h9:    rd_mux = status_byte;
      4'hA:    rd_mux = result_reg[7:0];
      4'hB:    rd_mux = result_reg[15:8];
      4'hC:    rd_mux = result_reg[23:16];
      4'hD:    rd_mux = result_reg[31:24];
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered read port: loads on a read strobe, holds otherwise.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_out <= 8'h00;
    end else if (rd_en) begin
      data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fpu_bus_interface.sv
// tb/tb_fpu_bus_interface.sv - self-checking bench for fpu_bus_interface with a stub fpu
`timescale 1ns/1ps
module tb_fpu_bus_interface;

  localparam int OP_W = 4;
  localparam int WDOG = 16;
  localparam int LAT  = 3;
  localparam logic [7:0] OP_SUB = 8'h01;

  logic            clk = 1'b0;
  logic            arst;
  logic            cs, wr, rd;
  logic [3:0]      addr;
  logic [7:0]      data_in;
  logic [7:0]      data_out;
  logic            irq;
  logic [31:0]     fpu_a_operand, fpu_b_operand;
  logic [OP_W-1:0] fpu_operation;
  logic            fpu_start;
  logic [31:0]     fpu_result;
  logic            fpu_cmd_end;
  logic            fpu_busy;

  int errors = 0;
  int checks = 0;

  // stub fpu: raises cmd_end LAT cycles after start, holds it until start drops
  logic        stub_hang, stub_force, stub_done;
  int          stub_cnt;
  logic [31:0] stub_result;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else if (fpu_start && !stub_hang && !stub_force) begin
      if (!stub_done) begin
        if (stub_cnt == LAT - 1) stub_done <= 1'b1;
        else stub_cnt <= stub_cnt + 1;
      end
    end else if (!fpu_start) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end
  end

  assign fpu_cmd_end = stub_done | stub_force;
  assign fpu_result  = stub_result;
  assign fpu_busy    = fpu_start & ~fpu_cmd_end;

  always #5 clk = ~clk;

  fpu_bus_interface #(.OP_W(OP_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .arst(arst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .data_in(data_in), .data_out(data_out), .irq(irq),
    .fpu_a_operand(fpu_a_operand), .fpu_b_operand(fpu_b_operand),
    .fpu_operation(fpu_operation), .fpu_start(fpu_start),
    .fpu_result(fpu_result), .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
  );

  typedef struct {
    logic       is_wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(posedge clk);
    #1;
    d = data_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic write32(input logic [3:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) bus_write(base + 4'(i), v[8*i +: 8]);
  endtask

  task automatic read32(input logic [3:0] base, output logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_read(base + 4'(i), b);
      v[8*i +: 8] = b;
    end
  endtask

  task automatic wait_done(input string name, input int max);
    logic [7:0] st;
    st = 8'h00;
    for (int i = 0; i < max; i++) begin
      bus_read(4'h9, st);
      if (st[1]) break;
    end
    check(name, {31'b0, st[1]}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rb;
    logic [31:0] r32;
    int          n;
    logic        seen, start_at_end;

    cs = 0; wr = 0; rd = 0; addr = 0; data_in = 0;
    stub_hang = 0; stub_force = 0; stub_result = 32'h0;

    // reset held for 1us
    arst = 1'b1;
    #1000;
    check("rst_data_out", {24'b0, data_out}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_fpu_start", {31'b0, fpu_start}, 32'h0);
    check("rst_a_operand", fpu_a_operand, 32'h0);
    @(negedge clk);
    arst = 1'b0;

    // register access vectors
    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'h4, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 4'h8, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 4'h9, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 4'hA, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 4'hD, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 4'hE, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 4'hF, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 4'h0, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 4'h1, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 4'h2, 8'h80, 8'h00};
    vecs[11] = '{1'b1, 4'h3, 8'h3F, 8'h00};
    vecs[12] = '{1'b1, 4'h4, 8'hCD, 8'h00};
    vecs[13] = '{1'b1, 4'h5, 8'hCC, 8'h00};
    vecs[14] = '{1'b1, 4'h6, 8'h8C, 8'h00};
    vecs[15] = '{1'b1, 4'h7, 8'h3F, 8'h00};
    vecs[16] = '{1'b1, 4'h8, 8'hF1, 8'h00};
    vecs[17] = '{1'b1, 4'hA, 8'h55, 8'h00};
    vecs[18] = '{1'b0, 4'h0, 8'h00, 8'h00};
    vecs[19] = '{1'b0, 4'h2, 8'h00, 8'h80};
    vecs[20] = '{1'b0, 4'h3, 8'h00, 8'h3F};
    vecs[21] = '{1'b0, 4'h4, 8'h00, 8'hCD};
    vecs[22] = '{1'b0, 4'h5, 8'h00, 8'hCC};
    vecs[23] = '{1'b0, 4'h7, 8'h00, 8'h3F};
    vecs[24] = '{1'b0, 4'h8, 8'h00, 8'h01};
    vecs[25] = '{1'b0, 4'hA, 8'h00, 8'h00};
    vecs[26] = '{1'b0, 4'hF, 8'h00, 8'h00};
    vecs[27] = '{1'b0, 4'h9, 8'h00, 8'h00};

    for (int i = 0; i < 28; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].a, vecs[i].d);
      end else begin
        bus_read(vecs[i].a, rb);
        check($sformatf("vec%0d_addr%0h", i, vecs[i].a), {24'b0, rb}, {24'b0, vecs[i].exp});
      end
    end
    check("a_operand", fpu_a_operand, 32'h3F80_0000);
    check("b_operand", fpu_b_operand, 32'h3F8C_CCCD);
    check("operation", {28'b0, fpu_operation}, {24'b0, OP_SUB});

    // op_sub 1.0 - 1.1
    stub_result = 32'hBDCC_CCD0;
    bus_write(4'h9, 8'h01);
    check("start_after_go", {31'b0, fpu_start}, 32'h1);
    wait_done("sub1_done", 40);
    read32(4'hA, r32);
    check("sub1_result", r32, 32'hBDCC_CCD0);
    bus_read(4'h9, rb);
    check("sub1_status", {24'b0, rb}, 32'h02);
    check("sub1_start_low", {31'b0, fpu_start}, 32'h0);

    // irq path and GO-to-done latency
    write32(4'h0, 32'h3FFF_FFFF);
    write32(4'h4, 32'h402D_F854);
    stub_result = 32'hBF37_E152;
    bus_write(4'h9, 8'h06);
    check("irq_after_ack", {31'b0, irq}, 32'h0);
    bus_write(4'h9, 8'h05);
    n = 0; seen = 0; start_at_end = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (fpu_cmd_end && !seen) begin seen = 1; start_at_end = fpu_start; end
      n = i;
      if (irq) break;
    end
    check("latency", n, LAT + 2);
    check("irq_high", {31'b0, irq}, 32'h1);
    check("start_held_to_cmd_end", {31'b0, start_at_end}, 32'h1);
    read32(4'hA, r32);
    check("sub2_result", r32, 32'hBF37_E152);
    bus_write(4'h9, 8'h06);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(4'h9, rb);
    check("sub2_status", {24'b0, rb}, 32'h04);

    // leftover high cmd_end must not complete
    stub_result = 32'h1234_5678;
    @(negedge clk);
    stub_force = 1'b1;
    repeat (2) @(posedge clk);
    bus_write(4'h9, 8'h01);
    repeat (4) @(posedge clk);
    bus_read(4'h9, rb);
    check("stale_cmd_end_status", {24'b0, rb}, 32'h01);
    @(negedge clk);
    stub_force = 1'b0;
    wait_done("stale_done", 40);
    read32(4'hA, r32);
    check("stale_result", r32, 32'h1234_5678);
    bus_write(4'h9, 8'h02);

    // writes while busy set err and are dropped; ACK clears err
    write32(4'h0, 32'h1122_3344);
    stub_hang = 1'b1;
    bus_write(4'h9, 8'h01);
    bus_write(4'h0, 8'hAA);
    bus_write(4'h9, 8'h01);
    bus_read(4'h9, rb);
    check("busy_err_status", {24'b0, rb}, 32'h09);
    bus_read(4'h0, rb);
    check("busy_a0_kept", {24'b0, rb}, 32'h44);
    check("busy_a_operand", fpu_a_operand, 32'h1122_3344);
    bus_write(4'h9, 8'h02);
    bus_read(4'h9, rb);
    check("ack_err_status", {24'b0, rb}, 32'h01);
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("arst_hang_start", {31'b0, fpu_start}, 32'h0);
    @(negedge clk);
    arst = 1'b0;
    stub_hang = 1'b0;
    bus_read(4'h9, rb);
    check("arst_hang_status", {24'b0, rb}, 32'h00);
    check("arst_a_cleared", fpu_a_operand, 32'h0);

    // reset two cycles after GO, then a fresh op
    write32(4'h0, 32'h3F80_0000);
    write32(4'h4, 32'h3F8C_CCCD);
    bus_write(4'h8, OP_SUB);
    stub_result = 32'hBDCC_CCD0;
    bus_write(4'h9, 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("arst_mid_start", {31'b0, fpu_start}, 32'h0);
    @(negedge clk);
    arst = 1'b0;
    bus_read(4'h9, rb);
    check("arst_mid_status", {24'b0, rb}, 32'h00);
    write32(4'h0, 32'h3F80_0000);
    write32(4'h4, 32'h3F8C_CCCD);
    bus_write(4'h8, OP_SUB);
    bus_write(4'h9, 8'h01);
    wait_done("fresh_done", 40);
    read32(4'hA, r32);
    check("fresh_result", r32, 32'hBDCC_CCD0);

`ifdef FPU_IF_WDOG_EN
    // watchdog abort with an fpu that never ends
    bus_write(4'h9, 8'h06);
    stub_hang = 1'b1;
    bus_write(4'h9, 8'h05);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (irq) break;
    end
    check("wdog_cycles", n, WDOG);
    check("wdog_start_low", {31'b0, fpu_start}, 32'h0);
    read32(4'hA, r32);
    check("wdog_result", r32, 32'h7FC0_0000);
    bus_read(4'h9, rb);
    check("wdog_status", {24'b0, rb}, 32'h0E);
    stub_hang = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
